// File: rtl/tone_pkg.sv
// Shared types and constants for the win/tie jingle player.
//   state_t    : jingle sequencer states
//   jingle_t   : which two-note jingle is playing
//   HP_*_100M  : default tone half-periods in clocks at 100 MHz
//   max3()     : elaboration-time helper for sizing the tone counter
package tone_pkg;

  typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_t;

  typedef enum logic [1:0] {JNG_TIE, JNG_RIGHT, JNG_LEFT} jingle_t;

  localparam int unsigned HP_LO_100M  = 190_840;  // ~262 Hz
  localparam int unsigned HP_MID_100M = 95_602;   // ~523 Hz
  localparam int unsigned HP_HI_100M  = 63_776;   // ~784 Hz

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/win_tone_player_if.sv
// Round-result strobes in, amplifier pins and busy flag out.
//   winrnd/right/tie : one-cycle strobes from the judge logic
//   speaker/gain/en  : amplifier pins
//   busy             : a jingle is in progress
// master = the game logic / bench side, slave = the tone player.
interface win_tone_player_if;
  logic winrnd;
  logic right;
  logic tie;
  logic speaker;
  logic gain;
  logic en;
  logic busy;

  modport master (output winrnd, right, tie, input speaker, gain, en, busy);
  modport slave  (input winrnd, right, tie, output speaker, gain, en, busy);
endinterface

// File: rtl/win_tone_player_square_wave_gen.sv
// Square-wave tone generator with a registered output.
//   clk, rst    : clock, async active-high reset
//   run         : the coming cycle is an audible note cycle
//   clear       : the coming cycle is the first of a note; restart phase
//   half_period : toggle interval in clocks (>= 1)
//   wave        : square wave, 0 whenever run is low
// Each edge with run high counts one cycle of the coming note, so the first
// toggle lands in the half_period-th cycle of the note.
module square_wave_gen #(
  parameter int unsigned HP_W  = 18,
  parameter int unsigned CNT_W = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] base_cnt;
  logic             base_wave;
  logic             at_end;

  // A clear restarts from phase zero and still counts this edge as cycle 1.
  always_comb begin
    base_cnt  = clear ? '0 : cnt;
    base_wave = clear ? 1'b0 : wave;
    at_end    = (HP_W'(base_cnt) == half_period - HP_W'(1));
  end

  // NOTE: the reset sits in the sensitivity list so the speaker drops the
  // moment rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!run) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge
      // values, independent of statement order.
      cnt  <= '0;
      wave <= 1'b0;
    end else if (at_end) begin
      cnt  <= '0;
      wave <= ~base_wave;
    end else begin
      cnt  <= base_cnt + CNT_W'(1);
      wave <= base_wave;
    end
  end

endmodule

// File: rtl/win_tone_player.sv
// Two-note jingle player for the tug-of-war game.
//   clk, rst : system clock, async active-high reset
//   bus      : win_tone_player_if.slave
//              winrnd/right/tie in; speaker/gain/en/busy out (all registered)
// Jingles: tie = LO,LO; right win = MID,HI; left win = HI,MID.
// Sequence: NOTE1 (NOTE_CYCLES) -> GAP (GAP_CYCLES) -> NOTE2 (NOTE_CYCLES).
// Strobes are only looked at in IDLE; tie beats winrnd. GAP_CYCLES >= 1.
module win_tone_player
  import tone_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned HP_LO       = HP_LO_100M,
  parameter int unsigned HP_MID      = HP_MID_100M,
  parameter int unsigned HP_HI       = HP_HI_100M,
  parameter bit          GAIN_HI     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  win_tone_player_if.slave   bus
);

  localparam int unsigned HP_MAX = max3(HP_LO, HP_MID, HP_HI);
  // half_period must hold HP itself; the counter only reaches HP-1.
  localparam int unsigned HP_W   = $clog2(HP_MAX + 1);
  localparam int unsigned CNT_W  = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  localparam logic [31:0]     NOTE_LEN  = 32'(NOTE_CYCLES);
  localparam logic [31:0]     NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0]     GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam bit              FIRST_RUN = (NOTE_CYCLES > 1);
  localparam logic [HP_W-1:0] HP_LO_V   = HP_W'(HP_LO);
  localparam logic [HP_W-1:0] HP_MID_V  = HP_W'(HP_MID);
  localparam logic [HP_W-1:0] HP_HI_V   = HP_W'(HP_HI);

  state_t          state;
  logic [31:0]     dur_cnt;
  logic [HP_W-1:0] hp1_q;
  logic [HP_W-1:0] hp2_q;

  logic            start;
  jingle_t         start_jng;
  logic [HP_W-1:0] start_hp1;
  logic [HP_W-1:0] start_hp2;

  logic            tone_run;
  logic            tone_clear;
  logic [HP_W-1:0] tone_hp;

  always_comb begin
    start = bus.tie | bus.winrnd;
    if (bus.tie)        start_jng = JNG_TIE;
    else if (bus.right) start_jng = JNG_RIGHT;
    else                start_jng = JNG_LEFT;

    case (start_jng)
      JNG_TIE:   begin start_hp1 = HP_LO_V;  start_hp2 = HP_LO_V;  end
      JNG_RIGHT: begin start_hp1 = HP_MID_V; start_hp2 = HP_HI_V;  end
      default:   begin start_hp1 = HP_HI_V;  start_hp2 = HP_MID_V; end
    endcase
  end

  // Tone controls describe the cycle after the coming edge: run is low on a
  // note's last cycle, which forces the speaker to 0 there.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    tone_run   = 1'b0;
    tone_clear = 1'b0;
    tone_hp    = hp2_q;
    case (state)
      IDLE: begin
        tone_hp = start_hp1;
        if (start) begin
          tone_clear = 1'b1;
          tone_run   = FIRST_RUN;
        end
      end
      NOTE1: begin
        tone_hp  = hp1_q;
        tone_run = (dur_cnt + 32'd2 < NOTE_LEN);
      end
      GAP: begin
        if (dur_cnt == GAP_LAST) begin
          tone_clear = 1'b1;
          tone_run   = FIRST_RUN;
        end
      end
      NOTE2: tone_run = (dur_cnt + 32'd2 < NOTE_LEN);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      hp1_q    <= '0;
      hp2_q    <= '0;
      bus.busy <= 1'b0;
      bus.en   <= 1'b0;
      bus.gain <= 1'b0;
    end else begin
      bus.gain <= GAIN_HI;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= NOTE1;
            dur_cnt  <= '0;
            hp1_q    <= start_hp1;
            hp2_q    <= start_hp2;
            bus.busy <= 1'b1;
            bus.en   <= 1'b1;
          end
        end
        NOTE1: begin
          if (dur_cnt == NOTE_LAST) begin
            state   <= GAP;
            dur_cnt <= '0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        GAP: begin
          if (dur_cnt == GAP_LAST) begin
            state   <= NOTE2;
            dur_cnt <= '0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        NOTE2: begin
          if (dur_cnt == NOTE_LAST) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            bus.busy <= 1'b0;
            bus.en   <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          dur_cnt  <= '0;
          bus.busy <= 1'b0;
          bus.en   <= 1'b0;
        end
      endcase
    end
  end

  square_wave_gen #(
    .HP_W  (HP_W),
    .CNT_W (CNT_W)
  ) u_tone (
    .clk         (clk),
    .rst         (rst),
    .run         (tone_run),
    .clear       (tone_clear),
    .half_period (tone_hp),
    .wave        (bus.speaker)
  );

endmodule

// File: tb/tb_win_tone_player.sv
// Self-checking bench for win_tone_player with short notes.
// Cycle n is the interval after the n-th rising edge; a strobe held during
// cycle n is sampled at the edge that starts cycle n+1. Inputs change 1 time
// unit after a rising edge, outputs are compared on the falling edge.
module tb_win_tone_player;

  localparam int NOTE = 20;
  localparam int GAPC = 4;
  localparam int LO   = 5;
  localparam int MID  = 3;
  localparam int HI   = 2;
  localparam int JLEN = 2 * NOTE + GAPC;
  localparam int HIST = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  win_tone_player_if bus ();

  win_tone_player #(
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAPC),
    .HP_LO       (LO),
    .HP_MID      (MID),
    .HP_HI       (HI),
    .GAIN_HI     (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A jingle started at cycle s is busy for offsets 1..JLEN. Inside a note,
  // cycle c (1-based) carries floor(c/hp) mod 2, except the last cycle is 0.
  int start_cyc = -1000;
  int m_hp1 = 0;
  int m_hp2 = 0;
  bit prev_rst = 1'b1;
  bit spk_hist [HIST];
  bit busy_hist[HIST];
  bit en_hist  [HIST];

  function automatic bit tone_at(input int c, input int hp);
    if (c >= NOTE) return 1'b0;
    return ((c / hp) % 2) == 1;
  endfunction

  always @(negedge clk) begin
    int o;
    bit e_busy;
    bit e_spk;
    bit e_gain;
    e_busy = 1'b0;
    e_spk  = 1'b0;
    e_gain = 1'b0;
    if (rst) begin
      start_cyc = -1000;
    end else begin
      o = cyc - start_cyc;
      if (o >= 1 && o <= JLEN) begin
        e_busy = 1'b1;
        if (o <= NOTE)             e_spk = tone_at(o, m_hp1);
        else if (o > NOTE + GAPC)  e_spk = tone_at(o - NOTE - GAPC, m_hp2);
      end
      e_gain = !prev_rst;
    end
    check("speaker", bus.speaker, e_spk);
    check("busy",    bus.busy,    e_busy);
    check("en",      bus.en,      e_busy);
    check("gain",    bus.gain,    e_gain);
    if (cyc < HIST) begin
      spk_hist[cyc]  = bus.speaker;
      busy_hist[cyc] = bus.busy;
      en_hist[cyc]   = bus.en;
    end
    if (!rst && !e_busy && (bus.tie || bus.winrnd)) begin
      start_cyc = cyc;
      if (bus.tie)        begin m_hp1 = LO;  m_hp2 = LO;  end
      else if (bus.right) begin m_hp1 = MID; m_hp2 = HI;  end
      else                begin m_hp1 = HI;  m_hp2 = MID; end
    end
    prev_rst = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic strobe(input logic w, input logic r, input logic t);
    bus.winrnd = w;
    bus.right  = r;
    bus.tie    = t;
    next_cycle();
    bus.winrnd = 1'b0;
    bus.right  = 1'b0;
    bus.tie    = 1'b0;
  endtask

  // Hand-computed shape of one jingle whose strobe was held in cycle base.
  task automatic check_jingle(input string name, input int base, input int t1, input int t2);
    int n1;
    int n2;
    bit gap_any;
    n1 = 0;
    n2 = 0;
    gap_any = 1'b0;
    for (int c = 2; c < NOTE; c++) begin
      if (spk_hist[base + c] != spk_hist[base + c - 1]) n1++;
      if (spk_hist[base + NOTE + GAPC + c] != spk_hist[base + NOTE + GAPC + c - 1]) n2++;
    end
    for (int g = NOTE + 1; g <= NOTE + GAPC; g++) gap_any |= spk_hist[base + g];
    check({name, "_note1_toggles"}, n1, t1);
    check({name, "_note2_toggles"}, n2, t2);
    check({name, "_busy_at_0"},     busy_hist[base], 0);
    check({name, "_busy_at_1"},     busy_hist[base + 1], 1);
    check({name, "_busy_at_44"},    busy_hist[base + JLEN], 1);
    check({name, "_en_at_44"},      en_hist[base + JLEN], 1);
    check({name, "_busy_at_45"},    busy_hist[base + JLEN + 1], 0);
    check({name, "_spk_at_44"},     spk_hist[base + JLEN], 0);
    check({name, "_gap_quiet"},     gap_any, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    bit soak_any;
    bus.winrnd = 1'b0;
    bus.right  = 1'b0;
    bus.tie    = 1'b0;
    rst        = 1'b1;

    idle(3);
    check("reset_gain", bus.gain, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    check("gain_before_edge", bus.gain, 0);
    next_cycle();
    check("gain_after_edge", bus.gain, 1);
    idle(2);

    // Right win: MID then HI.
    base = cyc;
    strobe(1'b1, 1'b1, 1'b0);
    idle(JLEN + 1);
    check_jingle("right", base, 6, 9);
    check("right_spk_c2", spk_hist[base + 2], 0);
    check("right_spk_c3", spk_hist[base + 3], 1);
    check("right_spk_n2c2", spk_hist[base + NOTE + GAPC + 2], 1);
    idle(2);

    // Left win: HI then MID.
    base = cyc;
    strobe(1'b1, 1'b0, 1'b0);
    idle(JLEN + 1);
    check_jingle("left", base, 9, 6);
    idle(2);

    // Tie and win together: tie jingle only.
    base = cyc;
    strobe(1'b1, 1'b1, 1'b1);
    idle(JLEN + 1);
    check_jingle("tie", base, 3, 3);
    check("tie_spk_c5", spk_hist[base + 5], 1);
    idle(2);

    // Strobe mid-jingle is dropped; strobe on the first idle cycle is taken.
    base = cyc;
    strobe(1'b1, 1'b1, 1'b0);
    idle(9);
    strobe(1'b1, 1'b0, 1'b0);
    idle(JLEN - 10);
    strobe(1'b0, 1'b0, 1'b1);
    check("b2b_busy_at_46", bus.busy, 1);
    idle(JLEN);
    check_jingle("ignored", base, 6, 9);
    check_jingle("b2b", base + JLEN + 1, 3, 3);
    idle(2);

    // Reset in the middle of NOTE1 (HI tone, speaker high at cycle 7).
    base = cyc;
    strobe(1'b1, 1'b0, 1'b0);
    idle(6);
    check("pre_rst_spk", bus.speaker, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_spk",  bus.speaker, 0);
    check("async_rst_en",   bus.en, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_gain", bus.gain, 0);
    idle(2);
    rst = 1'b0;
    check("rel_gain_before_edge", bus.gain, 0);
    next_cycle();
    check("rel_gain_after_edge", bus.gain, 1);
    check("rel_not_resumed", bus.busy, 0);
    base = cyc;
    strobe(1'b1, 1'b1, 1'b0);
    idle(JLEN + 1);
    check_jingle("after_rst", base, 6, 9);

    // Idle soak.
    base = cyc;
    idle(1000);
    soak_any = 1'b0;
    for (int k = base; k < base + 1000 && k < HIST; k++) soak_any |= spk_hist[k] | en_hist[k];
    check("soak_quiet", soak_any, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
